// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time of each complete input cycle,
// classifies the duty quartile, and flags an input that stops toggling.
module pwm_capture #(
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 12_500_000
) (
   input  logic             ext_clk_25m,
   input  logic             ext_rst,
   input  logic             i_pwm,
   output logic [CNT_W-1:0] o_period,
   output logic [CNT_W-1:0] o_high,
   output logic [1:0]       o_mode,
   output logic             o_valid,
   output logic             o_timeout,
   output logic             o_level
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic             s0_q, s1_q, prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_lat_q, hi_lat_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic [1:0]       mode_q, mode_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
   logic             level_q, level_d;

   logic             rise, fall, timed_out;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W+1:0] h4, p1, p2, p3;
   logic [1:0]       mode_dec;

   always_comb begin
      rise      = s1_q & ~prev_q;
      fall      = ~s1_q & prev_q;
      // saturating so a late edge at the timeout limit cannot wrap the count
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      timed_out = (cnt_q >= TO_VAL);

      h4 = {hi_lat_q, 2'b00};
      p1 = {2'b00, cnt_q};
      p2 = {1'b0, cnt_q, 1'b0};
      p3 = p1 + p2;
      if (h4 < p1)      mode_dec = 2'b00;
      else if (h4 < p2) mode_dec = 2'b01;
      else if (h4 < p3) mode_dec = 2'b10;
      else              mode_dec = 2'b11;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_lat_d  = hi_lat_q;
      period_d  = period_q;
      high_d    = high_q;
      mode_d    = mode_q;
      valid_d   = 1'b0;
      timeout_d = timeout_q;
      level_d   = level_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         HIGH: begin
            cnt_d = cnt_inc;
            if (fall) begin
               hi_lat_d = cnt_q;
               state_d  = LOW;
            end else if (timed_out) begin
               state_d   = IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
               level_d   = s1_q;
            end
         end
         LOW: begin
            cnt_d = cnt_inc;
            if (rise) begin
               period_d  = cnt_q;
               high_d    = hi_lat_q;
               mode_d    = mode_dec;
               valid_d   = 1'b1;
               timeout_d = 1'b0;
               cnt_d     = CNT_ONE;
               state_d   = HIGH;
            end else if (timed_out) begin
               state_d   = IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
               level_d   = s1_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge ext_clk_25m) begin
      if (ext_rst) begin
         state_q   <= IDLE;
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         prev_q    <= 1'b0;
         cnt_q     <= '0;
         hi_lat_q  <= '0;
         period_q  <= '0;
         high_q    <= '0;
         mode_q    <= 2'b00;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         level_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         s0_q      <= i_pwm;
         s1_q      <= s0_q;
         prev_q    <= s1_q;
         cnt_q     <= cnt_d;
         hi_lat_q  <= hi_lat_d;
         period_q  <= period_d;
         high_q    <= high_d;
         mode_q    <= mode_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         level_q   <= level_d;
      end
   end

   assign o_period  = period_q;
   assign o_high    = high_q;
   assign o_mode    = mode_q;
   assign o_valid   = valid_q;
   assign o_timeout = timeout_q;
   assign o_level   = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// directed boundary/stuck/reset scenarios plus randomized waveforms.
module tb_pwm_capture;

   localparam int CW = 16;
   localparam int TO = 100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pwm = 1'b0;
   logic [CW-1:0] o_period, o_high;
   logic [1:0]    o_mode;
   logic          o_valid, o_timeout, o_level;

   pwm_capture #(.CNT_W(CW), .TIMEOUT(TO)) dut (
      .ext_clk_25m(clk),
      .ext_rst    (rst),
      .i_pwm      (pwm),
      .o_period   (o_period),
      .o_high     (o_high),
      .o_mode     (o_mode),
      .o_valid    (o_valid),
      .o_timeout  (o_timeout),
      .o_level    (o_level)
   );

   always #20 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: the input seen by the measurement logic is i_pwm
   // delayed by two samples; measurements are differences of edge timestamps.
   int n = 0;
   bit smp [3];
   bit armed, hf, started;
   bit lv, pl, r, f;
   int t_rise, t_fall, el, q;
   int m_period, m_high, m_mode;
   bit m_valid, m_to, m_lvl;

   always @(posedge clk) begin
      lv = smp[1];
      pl = smp[2];
      m_valid = 1'b0;
      if (rst) begin
         smp[0] = 0; smp[1] = 0; smp[2] = 0;
         armed = 0; hf = 0;
         m_period = 0; m_high = 0; m_mode = 0;
         m_to = 0; m_lvl = 0;
      end else begin
         r = lv & ~pl;
         f = ~lv & pl;
         if (!armed) begin
            if (r) begin
               armed = 1; hf = 0; t_rise = n;
            end
         end else begin
            el = n - t_rise;
            if (r && hf) begin
               m_period = el;
               m_high   = t_fall - t_rise;
               q        = (m_high * 4) / m_period;
               m_mode   = (q > 3) ? 3 : q;
               m_valid  = 1;
               m_to     = 0;
               t_rise   = n;
               hf       = 0;
            end else if (f && !hf) begin
               hf = 1; t_fall = n;
            end else if (el >= TO) begin
               armed = 0; m_to = 1; m_lvl = lv;
            end
         end
         smp[2] = smp[1];
         smp[1] = smp[0];
         smp[0] = pwm;
      end
      n++;
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         chk("valid",   32'(o_valid),   32'(m_valid));
         chk("period",  32'(o_period),  32'(m_period));
         chk("high",    32'(o_high),    32'(m_high));
         chk("mode",    32'(o_mode),    32'(m_mode));
         chk("timeout", 32'(o_timeout), 32'(m_to));
         chk("level",   32'(o_level),   32'(m_lvl));
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic wave(input int per, input int hi, input int num);
      repeat (num) begin
         pwm = 1'b1;
         cyc(hi);
         pwm = 1'b0;
         cyc(per - hi);
      end
   endtask

   task automatic lit(input int per, input int hi, input int md);
      chk("lit_period", 32'(o_period), 32'(per));
      chk("lit_high",   32'(o_high),   32'(hi));
      chk("lit_mode",   32'(o_mode),   32'(md));
   endtask

   int lat;
   int per, hi, kind;

   initial begin
      rst = 1'b1;
      pwm = 1'b0;
      cyc(2);
      lit(0, 0, 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_to",    32'(o_timeout), 0);
      rst = 1'b0;
      cyc(3);

      // steady 80/24 (30%) and rise-to-valid latency
      wave(80, 24, 3);
      pwm = 1'b1;
      lat = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         lat++;
         if (o_valid) break;
      end
      chk("latency", 32'(lat), 3);
      lit(80, 24, 1);
      cyc(24 - lat);
      pwm = 1'b0;
      cyc(56);

      wave(80, 20, 3); lit(80, 20, 1);
      wave(80, 19, 3); lit(80, 19, 0);
      wave(80, 60, 3); lit(80, 60, 3);
      wave(2, 1, 10);  lit(2, 1, 2);

      // stuck high
      pwm = 1'b1;
      cyc(130);
      chk("stuckhi_to",  32'(o_timeout), 1);
      chk("stuckhi_lvl", 32'(o_level),   1);
      lit(2, 1, 2);
      pwm = 1'b0;
      cyc(10);
      wave(50, 10, 3);
      chk("resume_to", 32'(o_timeout), 0);
      lit(50, 10, 0);

      // stuck low, then one rise is not enough to report
      cyc(130);
      chk("stucklo_to",  32'(o_timeout), 1);
      chk("stucklo_lvl", 32'(o_level),   0);
      pwm = 1'b1;
      cyc(10);
      pwm = 1'b0;
      cyc(30);
      chk("one_rise_to", 32'(o_timeout), 1);
      wave(40, 10, 2);
      chk("recover_to", 32'(o_timeout), 0);
      lit(40, 10, 1);

      // reset while in LOW
      wave(60, 15, 2);
      pwm = 1'b1;
      cyc(15);
      pwm = 1'b0;
      cyc(20);
      rst = 1'b1;
      cyc(1);
      lit(0, 0, 0);
      chk("midrst_valid", 32'(o_valid), 0);
      rst = 1'b0;
      cyc(40);
      wave(60, 15, 2);
      lit(60, 15, 1);

      // randomized waveforms, stalls and resets
      repeat (60) begin
         kind = $urandom_range(0, 11);
         if (kind < 9) begin
            per = $urandom_range(2, 110);
            hi  = $urandom_range(1, per - 1);
            wave(per, hi, $urandom_range(1, 4));
         end else if (kind < 11) begin
            pwm = 1'($urandom_range(0, 1));
            cyc($urandom_range(90, 140));
         end else begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
         end
      end
      pwm = 1'b0;
      cyc(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
